// File: rtl/smart_led_frame_transmitter.sv
// smart_led_frame_transmitter: Manchester-coded single-wire LED word sender.
// Define PARITY_EN to append an even-parity bit after every word.
module smart_led_frame_transmitter #(
  parameter int HALF_BIT  = 8,
  parameter int GAP_BITS  = 4,
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_data,
  output logic                 out_enable,
  output logic                 busy,
  output logic [7:0]           word_count
);

  localparam int IDXW = $clog2(WORD_BITS);
  localparam int GAPW = $clog2(2 * GAP_BITS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TAIL  = 3'd3;
`ifdef PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  localparam logic [7:0] HB_LAST = 8'(HALF_BIT - 1);
  localparam logic [7:0] HB_PRE  = 8'(HALF_BIT - 2);
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'(2 * GAP_BITS - 1);
  localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(WORD_BITS - 1);

  logic [2:0]           r_state;
  logic [WORD_BITS-1:0] r_shreg;
  logic                 r_last;
  logic                 r_phase;
  logic                 r_pre;
  logic                 r_ready;
  logic                 r_data;
  logic                 r_oe;
  logic                 r_busy;
  logic [7:0]           r_hc;
  logic [7:0]           r_wc;
  logic [GAPW-1:0]      r_gap;
  logic [IDXW-1:0]      r_idx;
`ifdef PARITY_EN
  logic                 r_par;
`endif

  logic w_hb_end;
  logic w_gap_end;
  logic w_xfer;
  logic w_final;
  logic w_bit;
  logic w_word_end;
  logic w_ready_next;

  assign w_hb_end  = (r_hc == HB_LAST);
  assign w_gap_end = (r_gap == GAP_LAST);
  assign w_xfer    = in_valid && r_ready;

  // The final Manchester bit of a word is bit 0, or the parity bit.
`ifdef PARITY_EN
  assign w_final = (r_state == S_PARITY);
  assign w_bit   = w_final ? r_par : r_shreg[WORD_BITS-1];
`else
  assign w_final = (r_state == S_SHIFT) && (r_idx == '0);
  assign w_bit   = r_shreg[WORD_BITS-1];
`endif

  assign w_word_end   = w_final && r_phase && w_hb_end;
  assign w_ready_next = w_final && r_phase &&
                        (r_hc == HB_PRE) && !r_last;

  assign in_ready   = r_ready;
  assign out_data   = r_data;
  assign out_enable = r_oe;
  assign busy       = r_busy;
  assign word_count = r_wc;

  // Frame sequencer; line registers always hold the level being driven now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_last  <= 1'b0;
      r_phase <= 1'b0;
      r_pre   <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= 1'b0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_hc    <= '0;
      r_wc    <= '0;
      r_gap   <= '0;
      r_idx   <= '0;
`ifdef PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_oe   <= 1'b0;
          r_data <= 1'b0;
          if (w_xfer) begin
            r_shreg <= in_data;
            r_last  <= in_last;
`ifdef PARITY_EN
            r_par   <= ^in_data;
`endif
            r_wc    <= 8'd1;
            r_busy  <= 1'b1;
            r_pre   <= 1'b1;
            r_hc    <= '0;
            r_gap   <= '0;
            r_ready <= 1'b0;
            r_state <= S_LEAD;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_LEAD: begin
          if (r_pre) begin
            r_pre <= 1'b0;
            r_oe  <= 1'b1;
          end else if (!w_hb_end) begin
            r_hc <= r_hc + 8'd1;
          end else begin
            r_hc <= '0;
            if (w_gap_end) begin
              r_state <= S_SHIFT;
              r_data  <= ~r_shreg[WORD_BITS-1];
              r_idx   <= IDX_TOP;
              r_phase <= 1'b0;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        S_TAIL: begin
          if (!w_hb_end) begin
            r_hc <= r_hc + 8'd1;
          end else begin
            r_hc <= '0;
            if (w_gap_end) begin
              r_state <= S_IDLE;
              r_oe    <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        default: begin
          if (w_word_end) begin
            r_ready <= 1'b0;
            r_hc    <= '0;
            if (w_xfer) begin
              r_shreg <= in_data;
              r_last  <= in_last;
`ifdef PARITY_EN
              r_par   <= ^in_data;
`endif
              r_idx   <= IDX_TOP;
              r_phase <= 1'b0;
              r_data  <= ~in_data[WORD_BITS-1];
              r_state <= S_SHIFT;
              if (r_wc != 8'hFF) begin
                r_wc <= r_wc + 8'd1;
              end
            end else begin
              r_state <= S_TAIL;
              r_data  <= 1'b0;
              r_gap   <= '0;
            end
          end else if (!w_hb_end) begin
            r_hc <= r_hc + 8'd1;
            if (w_ready_next) begin
              r_ready <= 1'b1;
            end
          end else begin
            r_hc <= '0;
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_data  <= w_bit;
            end else if (r_idx != '0) begin
              r_idx   <= r_idx - 1'b1;
              r_phase <= 1'b0;
              r_shreg <= r_shreg << 1;
              r_data  <= ~r_shreg[WORD_BITS-2];
            end
`ifdef PARITY_EN
            else begin
              r_state <= S_PARITY;
              r_phase <= 1'b0;
              r_data  <= ~r_par;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smart_led_frame_transmitter.sv
// tb_smart_led_frame_transmitter: waveform-queue model plus directed frames.
// Checks line, handshake, busy and word_count on every falling edge.
module tb_smart_led_frame_transmitter;

  localparam int HB = 4;
  localparam int GB = 4;
  localparam int WB = 32;
  localparam int L  = 2 * GB * HB;
  localparam int DS = 1 + L;
`ifdef PARITY_EN
  localparam int WLEN = (WB + 1) * 2 * HB;
`else
  localparam int WLEN = WB * 2 * HB;
`endif
  localparam int WEND = DS + WLEN - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_data;
  logic        out_enable;
  logic        busy;
  logic [7:0]  word_count;

  smart_led_frame_transmitter #(
    .HALF_BIT (HB),
    .GAP_BITS (GB),
    .WORD_BITS(WB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_enable(out_enable),
    .busy      (busy),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic idle;
    logic oe;
    logic d;
    logic rdy;
    logic bsy;
    logic fin;
  } ent_t;

  ent_t       q[$];
  ent_t       cur = 6'b100000;
  logic [7:0] m_wc = '0;
  int         m_cyc = 0;
  int         m_xfers = 0;
  int         m_xcyc = 0;
  logic       m_xfer;
  int         checks = 0;
  int         failures = 0;
  bit         chk_en = 0;
  int         base;
  int         nx = 0;

  task automatic push_word(input logic [31:0] w, input logic last);
    logic bq[$];
    for (int i = WB - 1; i >= 0; i--) bq.push_back(w[i]);
`ifdef PARITY_EN
    bq.push_back(^w);
`endif
    for (int j = 0; j < bq.size(); j++) begin
      for (int h = 0; h < 2 * HB; h++) begin
        ent_t e;
        e.idle = 1'b0;
        e.oe   = 1'b1;
        e.d    = (h < HB) ? ~bq[j] : bq[j];
        e.fin  = (j == bq.size() - 1) && (h == 2 * HB - 1);
        e.rdy  = e.fin && !last;
        e.bsy  = 1'b1;
        q.push_back(e);
      end
    end
  endtask

  // Expected waveform: each accepted word appends its whole line pattern.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cur  = 6'b100000;
      m_wc = '0;
    end else begin
      m_cyc++;
      m_xfer = in_valid && cur.rdy;
      if (m_xfer) begin
        m_xfers++;
        m_xcyc = m_cyc;
        if (cur.idle) begin
          q.push_back(6'b000010);
          repeat (L) q.push_back(6'b010010);
          push_word(in_data, in_last);
          m_wc = 8'd1;
        end else begin
          push_word(in_data, in_last);
          if (m_wc != 8'hFF) m_wc++;
        end
      end else if (cur.fin) begin
        repeat (L) q.push_back(6'b010010);
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = {1'b1, 1'b0, 1'b0, cur.idle, 1'b0, 1'b0};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({out_enable, out_data, in_ready, busy, word_count} !==
          {cur.oe, cur.d, cur.rdy, cur.bsy, m_wc}) begin
        failures++;
        $display("FAIL model cyc=%0d oe/d/rdy/busy/wc got %b%b%b%b %0d want %b%b%b%b %0d",
                 m_cyc, out_enable, out_data, in_ready, busy, word_count,
                 cur.oe, cur.d, cur.rdy, cur.bsy, m_wc);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic at(input int k);
    int tgt;
    tgt = base + k;
    @(negedge clk);
    while (m_cyc < tgt) @(negedge clk);
    lit("cycle_align", m_cyc, tgt);
  endtask

  task automatic wait_xfer(input int n);
    int t;
    t = 0;
    while (m_xfers < n && t < 1000) begin
      @(posedge clk);
      #2;
      t++;
    end
    lit("xfer_seen", (m_xfers >= n) ? 1 : 0, 1);
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    @(posedge clk);
    #2;
    in_data  = w;
    in_last  = last;
    in_valid = 1'b1;
    nx++;
    wait_xfer(nx);
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_last  = 1'b0;
    base     = m_xcyc;
  endtask

  initial begin
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    #1;
    lit("rst_data", out_data, 0);
    lit("rst_oe", out_enable, 0);
    lit("rst_ready", in_ready, 0);
    lit("rst_busy", busy, 0);
    lit("rst_wc", word_count, 0);
    chk_en = 1;
    repeat (3) @(posedge clk);
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lit("ready_after_rst", in_ready, 1);

    send(32'hA5A5A5A5, 1'b1);
    at(0);
    lit("sw_oe0", out_enable, 0);
    lit("sw_busy0", busy, 1);
    at(1);
    lit("sw_oe1", out_enable, 1);
    at(DS - 1);
    lit("sw_lead_end", {out_enable, out_data}, 2'b10);
    at(DS);
    lit("sw_b31_lo", out_data, 0);
    at(DS + HB);
    lit("sw_b31_hi", out_data, 1);
    at(DS + 2 * HB);
    lit("sw_b30_hi", out_data, 1);
    at(WEND);
    lit("sw_last_rdy", in_ready, 0);
    at(WEND + 1);
    lit("sw_tail", {out_enable, out_data}, 2'b10);
    at(WEND + L);
    lit("sw_tail_end", out_enable, 1);
    at(WEND + L + 1);
    lit("sw_done", {out_enable, busy, in_ready}, 3'b000);
    lit("sw_wc", word_count, 1);
    at(WEND + L + 2);
    lit("sw_idle_rdy", in_ready, 1);

    send(32'h00000000, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    in_last  = 1'b1;
    at(WEND);
    lit("bb_rdy", in_ready, 1);
    nx++;
    wait_xfer(nx);
    in_valid = 1'b0;
    lit("bb_xfer_at", m_xcyc - base, WEND + 1);
    at(WEND + 1);
    lit("bb_w2_lo", out_data, 0);
    at(WEND + 1 + HB);
    lit("bb_w2_hi", out_data, 1);
    at(WEND + WLEN + 1);
    lit("bb_tail", {out_enable, out_data}, 2'b10);
    lit("bb_wc", word_count, 2);
    at(WEND + WLEN + L + 1);
    lit("bb_done", {out_enable, busy}, 2'b00);

    at(WEND + WLEN + L + 3);
    send(32'h12345678, 1'b0);
    at(DS);
    lit("ur_b31_hi", out_data, 1);
    at(WEND);
    lit("ur_rdy", in_ready, 1);
    at(WEND + 1);
    lit("ur_tail", {out_enable, out_data, busy}, 3'b101);
    at(WEND + L + 1);
    lit("ur_done", {out_enable, busy}, 2'b00);
    lit("ur_wc", word_count, 1);
    at(WEND + L + 3);

`ifdef PARITY_EN
    send(32'h00000001, 1'b1);
    at(DS + WB * 2 * HB);
    lit("par1_lo", out_data, 0);
    at(DS + WB * 2 * HB + HB);
    lit("par1_hi", out_data, 1);
    at(WEND + L + 3);
    send(32'h00000003, 1'b1);
    at(DS + WB * 2 * HB);
    lit("par0_hi", out_data, 1);
    at(DS + WB * 2 * HB + HB);
    lit("par0_lo", out_data, 0);
    at(WEND + L + 3);
`endif

    send(32'hA5A5A5A5, 1'b1);
    at(DS + 21 * 2 * HB + HB + 1);
    lit("mr_b10_hi", out_data, 1);
    #1;
    rst = 1'b1;
    #1;
    lit("mr_async", {out_data, out_enable, busy}, 3'b000);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lit("mr_ready", in_ready, 1);
    send(32'h80000000, 1'b1);
    at(1);
    lit("mr_oe", out_enable, 1);
    at(DS - 1);
    lit("mr_lead", {out_enable, out_data}, 2'b10);
    at(DS);
    lit("mr_b31_lo", out_data, 0);
    at(DS + HB);
    lit("mr_b31_hi", out_data, 1);
    at(WEND + L + 1);
    lit("mr_done", {out_enable, busy, word_count}, 10'h001);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout got running want finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
